// File: rtl/bias_add_stream.sv
// Streaming per-channel bias adder with a loadable sign-magnitude bias file and output saturation.
// Optional ReLU on the saturated result is enabled by defining BIAS_ADD_RELU_EN.
module bias_add_stream #(
  parameter int unsigned NUM_CH = 64,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bias_wr_en,
  input  logic [CH_W-1:0]   bias_wr_addr,
  input  logic [BIAS_W-1:0] bias_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              sat_flag
);

  localparam int unsigned MAG_W = BIAS_W - 1;
  localparam int unsigned BV_W  = DATA_W + 1;
  localparam int unsigned SUM_W = DATA_W + 2;

  logic [BIAS_W-1:0] r_bias [NUM_CH];
  logic [CH_W-1:0]   r_ch;

  logic              r_s1_valid;
  logic              r_s1_last;
  logic [DATA_W-1:0] r_s1_data;
  logic [CH_W-1:0]   r_s1_ch;
  logic [BV_W-1:0]   r_s1_bias;

  logic              w_adv;
  logic              w_accept;
  logic [BIAS_W-1:0] w_bias_raw;
  logic [BV_W-1:0]   w_bias_mag;
  logic [BV_W-1:0]   w_bias_tc;
  logic [SUM_W-1:0]  w_sum;
  logic              w_clamp;
  logic [DATA_W-1:0] w_sat;
  logic [DATA_W-1:0] w_res;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_accept = in_valid && w_adv;

  // Sign-magnitude to two's complement; negative zero naturally maps to 0.
  assign w_bias_raw = r_bias[r_ch];
  assign w_bias_mag = BV_W'(w_bias_raw[MAG_W-1:0]);
  assign w_bias_tc  = w_bias_raw[BIAS_W-1] ? -w_bias_mag : w_bias_mag;

  assign w_sum = {{2{r_s1_data[DATA_W-1]}}, r_s1_data} + {r_s1_bias[BV_W-1], r_s1_bias};

  // In range iff the top three sum bits agree; otherwise clamp toward the sum's sign.
  always_comb begin
    w_clamp = 1'b0;
    w_sat   = w_sum[DATA_W-1:0];
    if (w_sum[SUM_W-1:DATA_W-1] != {3{w_sum[SUM_W-1]}}) begin
      w_clamp = 1'b1;
      w_sat   = w_sum[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    w_res = w_sat;
`ifdef BIAS_ADD_RELU_EN
    if (w_sat[DATA_W-1]) begin
      w_res = '0;
    end
`endif
  end

  // Bias register file; writes are independent of the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_bias[CH_W'(i)] <= '0;
      end
    end else if (bias_wr_en && (32'(bias_wr_addr) < NUM_CH)) begin
      r_bias[bias_wr_addr] <= bias_wr_data;
    end
  end

  // Channel counter and two-stage pipeline, both gated by the shared advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch       <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_data  <= '0;
      r_s1_ch    <= '0;
      r_s1_bias  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      out_last   <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ch <= (in_last || (r_ch == CH_W'(NUM_CH - 1))) ? '0 : r_ch + CH_W'(1);
      end
      if (w_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data <= in_data;
          r_s1_last <= in_last;
          r_s1_ch   <= r_ch;
          r_s1_bias <= w_bias_tc;
        end
        out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          out_data <= w_res;
          out_ch   <= r_s1_ch;
          out_last <= r_s1_last;
          if (w_clamp) begin
            sat_flag <= 1'b1;
          end
        end
      end
    end
  end

endmodule
